// File: rtl/ddr_lane_pkg.sv
// Shared types and constants for the dual-edge lane arbiter.
//   lane_state_t : lane FSM states (idle, shifting a word, inter-word gap)
//   REQ0 / REQ1  : requester identifiers used for grant and grant_id
package ddr_lane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } lane_state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage : ddr_lane_pkg

// File: rtl/ddr_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The last_grant history register lives in the parent so that it only
// advances on an actual handshake.
// Ports:
//   valid[1:0]  in   request vector, bit N = requester N
//   last_grant  in   requester granted most recently
//   grant       out  winning requester (meaningful only when any=1)
//   any         out  at least one requester is valid
module ddr_rr_arb2
    import ddr_lane_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant = REQ0;
        any   = |valid;
        if (valid == 2'b11) begin
            // Tie: whoever did not win last time goes next.
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = REQ1;
        end
    end

endmodule : ddr_rr_arb2

// File: rtl/ddr_lane_arbiter.sv
// Shares one dual-edge output lane between two word requesters.
// A round-robin winner is accepted with a valid/ready handshake while the
// lane is idle. The word is then serialised MSB-first, two bits per clock:
// d_rise feeds the posedge capture of the dual-edge flop and d_fall feeds
// its negedge capture. GAP idle cycles follow each word.
// Ports:
//   clk, reset              sole clock; synchronous active-high reset
//   req0_valid/data/ready   requester 0 handshake and word
//   req1_valid/data/ready   requester 1 handshake and word
//   d_rise, d_fall          lane bits for the rising and falling halves
//   lane_en                 lane carries valid bits this cycle
//   grant_id                requester that owns the word in flight
//   word_done               final shift cycle of a word
//   busy                    lane FSM not idle
module ddr_lane_arbiter
    import ddr_lane_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             d_rise,
    output logic             d_fall,
    output logic             lane_en,
    output logic             grant_id,
    output logic             word_done,
    output logic             busy
);

    // Shift cycles per word minus one; the counter is kept at least one bit
    // wide so that WIDTH=2 still elaborates.
    localparam int                CNT_W    = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH / 2 - 1);
    localparam logic [3:0]        GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    lane_state_t      state;
    lane_state_t      state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       gap_cnt;
    logic             last_grant;

    logic             arb_grant;
    logic             arb_any;
    logic             accept;

    ddr_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    // The arbiter only ever picks a valid requester, so any valid in IDLE
    // means a handshake completes this cycle.
    assign accept = (state == ST_IDLE) && arb_any;

    always_comb begin
        req0_ready = (state == ST_IDLE) && req0_valid && (arb_grant == REQ0);
        req1_ready = (state == ST_IDLE) && req1_valid && (arb_grant == REQ1);
        busy       = (state != ST_IDLE);
        lane_en    = 1'b0;
        d_rise     = 1'b0;
        d_fall     = 1'b0;
        word_done  = 1'b0;
        state_nxt  = state;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                lane_en = 1'b1;
                d_rise  = shreg[WIDTH-1];
                d_fall  = shreg[WIDTH-2];
                if (cnt == '0) begin
                    word_done = 1'b1;
                    state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            cnt        <= '0;
            gap_cnt    <= 4'd0;
            grant_id   <= REQ0;
            last_grant <= REQ1;  // so requester 0 wins the first tie
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg      <= (arb_grant == REQ1) ? req1_data : req0_data;
                        grant_id   <= arb_grant;
                        last_grant <= arb_grant;
                        cnt        <= CNT_LOAD;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg << 2;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : ddr_lane_arbiter

// File: tb/tb_ddr_lane_arbiter.sv
// Self-checking bench for ddr_lane_arbiter.
// A slot-schedule model predicts every cycle: an accepted word becomes
// WIDTH/2 lane slots followed by GAP idle slots; an empty schedule means the
// lane is idle and the round-robin rule decides ready. Directed scenarios add
// hand-computed literal expectations; a GAP=0 instance covers back-to-back words.
module tb_ddr_lane_arbiter;

    localparam int W   = 8;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset      = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data  = '0;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data  = '0;
    logic         req0_ready, req1_ready;
    logic         d_rise, d_fall, lane_en, grant_id, word_done, busy;

    logic         g0_reset      = 1'b1;
    logic         g0_req0_valid = 1'b0;
    logic [W-1:0] g0_req0_data  = '0;
    logic         g0_req0_ready, g0_req1_ready;
    logic         g0_d_rise, g0_d_fall, g0_lane_en, g0_grant_id, g0_word_done, g0_busy;

    ddr_lane_arbiter #(.WIDTH(W), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .d_rise     (d_rise),
        .d_fall     (d_fall),
        .lane_en    (lane_en),
        .grant_id   (grant_id),
        .word_done  (word_done),
        .busy       (busy)
    );

    ddr_lane_arbiter #(.WIDTH(W), .GAP(0)) dut_g0 (
        .clk        (clk),
        .reset      (g0_reset),
        .req0_valid (g0_req0_valid),
        .req0_data  (g0_req0_data),
        .req0_ready (g0_req0_ready),
        .req1_valid (1'b0),
        .req1_data  (8'h00),
        .req1_ready (g0_req1_ready),
        .d_rise     (g0_d_rise),
        .d_fall     (g0_d_fall),
        .lane_en    (g0_lane_en),
        .grant_id   (g0_grant_id),
        .word_done  (g0_word_done),
        .busy       (g0_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic en;
        logic rise;
        logic fall;
        logic done;
    } slot_t;

    slot_t sched[$];
    logic  m_last = 1'b1;
    logic  m_gid  = 1'b0;

    always @(negedge clk) begin : model
        slot_t        s;
        logic         g, er0, er1, bsy;
        logic [W-1:0] word;
        #1;
        if (reset) begin
            sched.delete();
            m_last = 1'b1;
            m_gid  = 1'b0;
        end else begin
            er0 = 1'b0;
            er1 = 1'b0;
            g   = 1'b0;
            if (sched.size() != 0) begin
                s   = sched.pop_front();
                bsy = 1'b1;
            end else begin
                s   = '{en: 1'b0, rise: 1'b0, fall: 1'b0, done: 1'b0};
                bsy = 1'b0;
                g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                er0 = req0_valid && !g;
                er1 = req1_valid && g;
            end
            check("m_req0_ready", req0_ready, er0);
            check("m_req1_ready", req1_ready, er1);
            check("m_lane_en",    lane_en,    s.en);
            check("m_d_rise",     d_rise,     s.rise);
            check("m_d_fall",     d_fall,     s.fall);
            check("m_word_done",  word_done,  s.done);
            check("m_busy",       busy,       bsy);
            check("m_grant_id",   grant_id,   m_gid);
            if (er0 || er1) begin
                word = g ? req1_data : req0_data;
                for (int k = 0; k < W / 2; k++) begin
                    sched.push_back('{en: 1'b1, rise: word[W-1-2*k], fall: word[W-2-2*k],
                                      done: (k == W / 2 - 1)});
                end
                for (int k = 0; k < GAP; k++) begin
                    sched.push_back('{en: 1'b0, rise: 1'b0, fall: 1'b0, done: 1'b0});
                end
                m_gid  = g;
                m_last = g;
            end
        end
    end

    // One cycle of stimulus; returns just after the model compare so literal
    // checks see the same cycle's outputs.
    task automatic drive(input logic r, input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1);
        @(negedge clk);
        reset      = r;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        #2;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin : stim
        logic [7:0] pat;
        int         ph;
        logic       odd;
        logic       p0, p1, r;
        logic [W-1:0] rd0, rd1;

        // 1: single word 8'hB4 from requester 0
        do_reset();
        drive(1'b0, 1'b1, 8'hB4, 1'b0, '0);
        check("t1_ready0", req0_ready, 1'b1);
        check("t1_busy_idle", busy, 1'b0);
        pat = 8'b10_11_01_00;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            check("t1_lane_en", lane_en, 1'b1);
            check("t1_rise", d_rise, pat[7-2*k]);
            check("t1_fall", d_fall, pat[6-2*k]);
            check("t1_done", word_done, (k == 3));
            check("t1_gid", grant_id, 1'b0);
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        check("t1_gap_lane", lane_en, 1'b0);
        check("t1_gap_busy", busy, 1'b1);

        // 2: both valid continuously, alternating grants, period WIDTH/2+GAP+1
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, 8'hFF, 1'b1, 8'h00);
            ph  = i % 6;
            odd = ((i / 6) % 2) == 1;
            check("t2_lane_en", lane_en, (ph >= 1 && ph <= 4));
            check("t2_ready0", req0_ready, (ph == 0) && !odd);
            check("t2_ready1", req1_ready, (ph == 0) && odd);
            if (ph >= 1 && ph <= 4) begin
                check("t2_gid", grant_id, odd);
                check("t2_rise", d_rise, !odd);
                check("t2_fall", d_fall, !odd);
            end
        end

        // 3: requester 1 alone, three words
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 8'h5A);
            ph = i % 6;
            check("t3_ready1", req1_ready, (ph == 0));
            check("t3_ready0", req0_ready, 1'b0);
            if (ph >= 1 && ph <= 4) check("t3_gid", grant_id, 1'b1);
        end

        // 4: reset in the second shift cycle drops the word
        do_reset();
        drive(1'b0, 1'b1, 8'hB4, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        check("t4_lane_en", lane_en, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_done", word_done, 1'b0);
        check("t4_rise", d_rise, 1'b0);
        check("t4_fall", d_fall, 1'b0);
        drive(1'b0, 1'b1, 8'hB4, 1'b1, 8'h5A);
        check("t4_ready0", req0_ready, 1'b1);
        check("t4_ready1", req1_ready, 1'b0);

        // 6: requester 1 arrives mid-word and waits for the first idle cycle
        do_reset();
        drive(1'b0, 1'b1, 8'hB4, 1'b0, '0);
        check("t6_ready0", req0_ready, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1, 8'hC3);
            check("t6_wait1", req1_ready, 1'b0);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 8'hC3);
        check("t6_ready1", req1_ready, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        check("t6_after1", req1_ready, 1'b0);

        // 5: GAP=0 instance, continuous requester 0 with 8'hB4
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g0_reset      = 1'b0;
            g0_req0_valid = 1'b1;
            g0_req0_data  = 8'hB4;
            #2;
            ph = i % 5;
            check("t5_lane_en", g0_lane_en, (ph != 0));
            check("t5_done", g0_word_done, (ph == 4));
            check("t5_ready0", g0_req0_ready, (ph == 0));
            check("t5_busy", g0_busy, (ph != 0));
            check("t5_rise", g0_d_rise, (ph == 1 || ph == 2));
        end
        @(negedge clk);
        g0_req0_valid = 1'b0;

        // Random traffic against the model, with occasional resets
        do_reset();
        p0  = 1'b0;
        p1  = 1'b0;
        rd0 = '0;
        rd1 = '0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 149) == 0);
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0  = 1'b1;
                rd0 = W'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1  = 1'b1;
                rd1 = W'($urandom);
            end
            drive(r, p0, rd0, p1, rd1);
            if (!r && req0_ready) p0 = 1'b0;
            if (!r && req1_ready) p1 = 1'b0;
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ddr_lane_arbiter
